edac_recovery_ctrl: RTL and testbench

Timing-error recovery sequencer for the EDAC build of the RISCV core. It OR-reduces the per-flop error-detect vector, stalls and flushes the pipeline, then holds it for a fixed replay window and releases it. It maintains saturating error counters and raises a sticky degrade request when errors cluster. It sits beside RISCV and drives the core's stall/flush inputs; tests read its counters in place of the bench-side err_cnt.

---
 rtl/edac_pkg.sv | 16 +
 rtl/edac_recovery_ctrl_if.sv | 36 +++
 rtl/sat_counter.sv | 22 ++
 rtl/edac_recovery_ctrl.sv | 100 ++++++++++
 tb/tb_edac_recovery_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/edac_pkg.sv
// edac_pkg: shared types, default widths and saturating increment for the EDAC recovery controller
package edac_pkg;

    typedef enum logic [1:0] {IDLE, FLUSH, REPLAY, RESUME} state_t;

    localparam int ERR_W_DEF = 269;
    localparam int CNT_W_DEF = 16;

    // Increments v unless it already holds the all-ones value of a w-bit field (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] max;
        max = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
        return (v == max) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/edac_recovery_ctrl_if.sv
// edac_recovery_ctrl_if: core-side signal bundle of the recovery controller
//   err_i      per-flop timing-error flags from the core
//   clear_i    clears counters and degrade_o
//   stall_o    pipeline freeze
//   flush_o    one-cycle flush pulse
//   replay_o   one-cycle resume/re-execute pulse
//   busy_o     controller not idle
//   err_cnt_o  saturating accepted-event count
//   mask_cnt_o saturating count of errors seen while busy
//   degrade_o  sticky frequency-lowering request
interface edac_recovery_ctrl_if
    import edac_pkg::*;
#(
    parameter int ERR_W = ERR_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) ();
    logic [ERR_W-1:0] err_i;
    logic             clear_i;
    logic             stall_o;
    logic             flush_o;
    logic             replay_o;
    logic             busy_o;
    logic [CNT_W-1:0] err_cnt_o;
    logic [CNT_W-1:0] mask_cnt_o;
    logic             degrade_o;

    modport master (
        output err_i, clear_i,
        input  stall_o, flush_o, replay_o, busy_o, err_cnt_o, mask_cnt_o, degrade_o
    );

    modport slave (
        input  err_i, clear_i,
        output stall_o, flush_o, replay_o, busy_o, err_cnt_o, mask_cnt_o, degrade_o
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: W-bit counter that sticks at all-ones
//   clk  clock
//   rst  synchronous reset, active-low
//   clr  synchronous clear, wins over inc
//   inc  count enable
//   q    count value
module sat_counter
    import edac_pkg::*;
#(
    parameter int W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (!rst || clr) q <= '0;
        else if (inc) q <= W'(sat_inc(32'(q), W));
    end
endmodule

// File: rtl/edac_recovery_ctrl.sv
// edac_recovery_ctrl: timing-error recovery sequencer (stall, flush, replay window, release) with burst-based degrade request
//   clk  rising-edge clock shared with the core
//   rst  synchronous reset, active-low
//   bus  slave side of edac_recovery_ctrl_if (err_i/clear_i in; stall/flush/replay/busy/counters/degrade out)
module edac_recovery_ctrl
    import edac_pkg::*;
#(
    parameter int ERR_W      = ERR_W_DEF,
    parameter int REPLAY_CYC = 2,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int WIN_CYC    = 32,
    parameter int BURST_TH   = 3
) (
    input logic                 clk,
    input logic                 rst,
    edac_recovery_ctrl_if.slave bus
);
    state_t           state, nxt;
    logic [ERR_W-1:0] err_v;
    logic             err_q;
    logic [3:0]       rcnt;
    logic [7:0]       wcnt;
    logic [3:0]       burst;
    logic             stall, flush, replay, busy, degrade;
    logic             accept, mask;
    logic [CNT_W-1:0] err_cnt, mask_cnt;

    assign err_v = bus.err_i;

    // Errors in IDLE or RESUME start a sequence; errors in FLUSH/REPLAY are only counted.
    assign accept = err_q && (state == IDLE || state == RESUME);
    assign mask   = err_q && (state == FLUSH || state == REPLAY);

    always_comb begin
        nxt = state == FLUSH  ? REPLAY :
              state == REPLAY ? (rcnt == 4'd0 ? RESUME : REPLAY) :
              err_q           ? FLUSH : IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            err_q   <= 1'b0;
            rcnt    <= '0;
            wcnt    <= '0;
            burst   <= '0;
            degrade <= 1'b0;
            stall   <= 1'b0;
            flush   <= 1'b0;
            replay  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            // An X flag reads as "no error" rather than propagating into the FSM.
            err_q  <= ((|err_v) === 1'b1);
            state  <= nxt;
            stall  <= nxt inside {FLUSH, REPLAY};
            flush  <= nxt == FLUSH;
            replay <= nxt == RESUME;
            busy   <= nxt != IDLE;
            if (state == FLUSH) rcnt <= 4'(REPLAY_CYC - 1);
            else if (state == REPLAY && rcnt != 4'd0) rcnt <= rcnt - 4'd1;
            // The burst window opens each time the sequencer falls back to IDLE.
            if (state != IDLE && nxt == IDLE) wcnt <= 8'(WIN_CYC);
            else if (state == IDLE && wcnt != 8'd0) wcnt <= wcnt - 8'd1;
            if (bus.clear_i) begin
                burst   <= '0;
                degrade <= 1'b0;
            end else if (accept) begin
                burst <= 4'(sat_inc(32'(burst), 4));
                if (32'(burst) + 32'd1 >= 32'(BURST_TH)) degrade <= 1'b1;
            end else if (state == IDLE && wcnt == 8'd0) begin
                burst <= '0;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_err_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clear_i),
        .inc (accept),
        .q   (err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mask_cnt (
        .clk (clk),
        .rst (rst),
        .clr (bus.clear_i),
        .inc (mask),
        .q   (mask_cnt)
    );

    assign bus.stall_o    = stall;
    assign bus.flush_o    = flush;
    assign bus.replay_o   = replay;
    assign bus.busy_o     = busy;
    assign bus.degrade_o  = degrade;
    assign bus.err_cnt_o  = err_cnt;
    assign bus.mask_cnt_o = mask_cnt;
endmodule

// File: tb/tb_edac_recovery_ctrl.sv
// tb_edac_recovery_ctrl: scoreboard bench for edac_recovery_ctrl (flush timing/count queue plus per-scenario checks)
module tb_edac_recovery_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        int          c;
        logic [15:0] cnt;
    } exp_t;
    exp_t exp_q[$];

    edac_recovery_ctrl_if #(.ERR_W(269), .CNT_W(16)) bus ();
    edac_recovery_ctrl_if #(.ERR_W(269), .CNT_W(4))  sbus ();

    edac_recovery_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    edac_recovery_ctrl #(.CNT_W(4), .BURST_TH(15)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (sbus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Every flush pulse must match the oldest expected sequence start (cycle and err_cnt).
    always @(negedge clk) begin
        if (bus.flush_o === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL flush_unexpected cycle %0d err_cnt %0h", cyc, bus.err_cnt_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (cyc !== e.c || bus.err_cnt_o !== e.cnt) begin
                    errors++;
                    $display("FAIL flush_seq got cycle %0d cnt %0h want cycle %0d cnt %0h", cyc, bus.err_cnt_o, e.c, e.cnt);
                end
            end
        end
    end

    task automatic push_flush(input int c, input logic [15:0] cnt);
        exp_t e;
        e.c   = c;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        bus.err_i = '0;
        bus.clear_i = 1'b0;
        sbus.err_i = '0;
        sbus.clear_i = 1'b0;
        idle(3);
        rst = 1'b1;
    endtask

    task automatic run(input logic [127:0] pat, input int len, input int b);
        for (int k = 0; k < len; k++) begin
            bus.err_i = '0;
            if (pat[k]) bus.err_i[b] = 1'b1;
            idle(1);
        end
        bus.err_i = '0;
    endtask

    task automatic chk_cnt(input string name, input logic [15:0] ec, input logic [15:0] mc);
        checks++;
        if (bus.err_cnt_o !== ec || bus.mask_cnt_o !== mc) begin
            errors++;
            $display("FAIL %s got err %0h mask %0h want err %0h mask %0h", name, bus.err_cnt_o, bus.mask_cnt_o, ec, mc);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 20; k++) begin
            checks++;
            if ({bus.stall_o, bus.flush_o, bus.replay_o, bus.busy_o, bus.degrade_o, bus.err_cnt_o, bus.mask_cnt_o} !== '0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d got %b/%0h/%0h want 0", k, {bus.stall_o, bus.flush_o, bus.replay_o, bus.busy_o, bus.degrade_o}, bus.err_cnt_o, bus.mask_cnt_o);
            end
            idle(1);
        end
    endtask

    task automatic test_single();
        logic [3:0] shape [7];
        logic [3:0] got;
        shape = '{4'b0000, 4'b0000, 4'b1101, 4'b1001, 4'b1001, 4'b0011, 4'b0000};
        do_reset();
        idle(3);
        push_flush(cyc + 2, 16'd1);
        bus.err_i[5] = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            if (k == 1) bus.err_i = '0;
            got = {bus.stall_o, bus.flush_o, bus.replay_o, bus.busy_o};
            checks++;
            if (got !== shape[k]) begin
                errors++;
                $display("FAIL single_shape step %0d got %b want %b", k, got, shape[k]);
            end
            idle(1);
        end
        chk_cnt("single_cnt", 16'd1, 16'd0);
    endtask

    task automatic test_mask();
        int n;
        do_reset();
        idle(3);
        n = cyc;
        push_flush(n + 2, 16'd1);
        run(128'b1101, 10, 3);
        idle(4);
        chk_cnt("mask_cnt", 16'd1, 16'd2);
        do_reset();
        idle(3);
        n = cyc;
        push_flush(n + 2, 16'd1);
        push_flush(n + 6, 16'd2);
        run(128'b10001, 6, 0);
        idle(8);
        chk_cnt("resume_accept", 16'd2, 16'd0);
    endtask

    task automatic test_burst();
        int n;
        logic [127:0] pat;
        do_reset();
        idle(3);
        n = cyc;
        push_flush(n + 2, 16'd1);
        push_flush(n + 12, 16'd2);
        push_flush(n + 22, 16'd3);
        pat = '0;
        pat[0] = 1'b1;
        pat[10] = 1'b1;
        pat[20] = 1'b1;
        run(pat, 21, 7);
        checks++;
        if (bus.degrade_o !== 1'b0 || bus.err_cnt_o !== 16'd2) begin
            errors++;
            $display("FAIL burst_pre got deg %b err %0h want deg 0 err 2", bus.degrade_o, bus.err_cnt_o);
        end
        idle(1);
        checks++;
        if (bus.degrade_o !== 1'b1 || bus.err_cnt_o !== 16'd3) begin
            errors++;
            $display("FAIL burst_rise got deg %b err %0h want deg 1 err 3", bus.degrade_o, bus.err_cnt_o);
        end
        idle(60);
        checks++;
        if (bus.degrade_o !== 1'b1) begin
            errors++;
            $display("FAIL burst_sticky got %b want 1", bus.degrade_o);
        end
        bus.clear_i = 1'b1;
        idle(1);
        bus.clear_i = 1'b0;
        checks++;
        if (bus.degrade_o !== 1'b0) begin
            errors++;
            $display("FAIL burst_clear got %b want 0", bus.degrade_o);
        end
        chk_cnt("burst_clear_cnt", 16'd0, 16'd0);
        do_reset();
        idle(3);
        n = cyc;
        push_flush(n + 2, 16'd1);
        push_flush(n + 42, 16'd2);
        push_flush(n + 82, 16'd3);
        pat = '0;
        pat[0] = 1'b1;
        pat[40] = 1'b1;
        pat[80] = 1'b1;
        run(pat, 81, 9);
        idle(4);
        checks++;
        if (bus.degrade_o !== 1'b0 || bus.err_cnt_o !== 16'd3) begin
            errors++;
            $display("FAIL burst_window got deg %b err %0h want deg 0 err 3", bus.degrade_o, bus.err_cnt_o);
        end
    endtask

    task automatic test_clear_event();
        int n;
        do_reset();
        idle(3);
        push_flush(cyc + 2, 16'd1);
        run(128'b1, 8, 0);
        n = cyc;
        push_flush(n + 2, 16'd0);
        bus.err_i[1] = 1'b1;
        idle(1);
        bus.err_i = '0;
        bus.clear_i = 1'b1;
        idle(1);
        bus.clear_i = 1'b0;
        checks++;
        if (bus.busy_o !== 1'b1 || bus.flush_o !== 1'b1 || bus.err_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL clear_with_event got busy %b flush %b err %0h want 1 1 0", bus.busy_o, bus.flush_o, bus.err_cnt_o);
        end
        idle(6);
        chk_cnt("clear_after", 16'd0, 16'd0);
    endtask

    task automatic test_saturate();
        do_reset();
        idle(3);
        sbus.err_i = '1;
        idle(53);
        sbus.err_i = '0;
        idle(6);
        checks++;
        if (sbus.err_cnt_o !== 4'hE || sbus.mask_cnt_o !== 4'hF) begin
            errors++;
            $display("FAIL sat_preload got err %0h mask %0h want e f", sbus.err_cnt_o, sbus.mask_cnt_o);
        end
        for (int k = 0; k < 3; k++) begin
            sbus.err_i[0] = 1'b1;
            idle(1);
            sbus.err_i = '0;
            idle(9);
            checks++;
            if (sbus.err_cnt_o !== 4'hF) begin
                errors++;
                $display("FAIL sat_hold event %0d got %0h want f", k, sbus.err_cnt_o);
            end
        end
    endtask

    task automatic test_x();
        logic xe;
        do_reset();
        idle(3);
        bus.err_i[100] = 1'bx;
        xe = ((|bus.err_i) === 1'b1);
        if (xe) push_flush(cyc + 2, 16'd1);
        idle(1);
        bus.err_i = '0;
        idle(8);
        chk_cnt("x_flag", xe ? 16'd1 : 16'd0, 16'd0);
    endtask

    task automatic test_reset_replay();
        do_reset();
        idle(3);
        push_flush(cyc + 2, 16'd1);
        bus.err_i[0] = 1'b1;
        idle(1);
        bus.err_i = '0;
        idle(2);
        checks++;
        if (bus.stall_o !== 1'b1 || bus.busy_o !== 1'b1) begin
            errors++;
            $display("FAIL replay_entry got stall %b busy %b want 1 1", bus.stall_o, bus.busy_o);
        end
        rst = 1'b0;
        idle(1);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({bus.stall_o, bus.flush_o, bus.replay_o, bus.busy_o, bus.err_cnt_o, bus.mask_cnt_o} !== '0) begin
                errors++;
                $display("FAIL reset_mid step %0d got %b/%0h/%0h want 0", k, {bus.stall_o, bus.flush_o, bus.replay_o, bus.busy_o}, bus.err_cnt_o, bus.mask_cnt_o);
            end
            idle(1);
        end
    endtask

    initial begin
        bus.err_i = '0;
        bus.clear_i = 1'b0;
        sbus.err_i = '0;
        sbus.clear_i = 1'b0;
        test_reset();
        test_single();
        test_mask();
        test_burst();
        test_clear_event();
        test_saturate();
        test_x();
        test_reset_replay();
        idle(4);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL flush_missing got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
